// File: rtl/data_mem_arbiter.sv
// Shares one data memory port between the pipeline MEM stage and a debug/loader requester.
// The pipeline has priority; debug takes idle slots, is forced in after STARVE_LIMIT blocked cycles, and can hold the port.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pipe_read,
  input  logic                  pipe_write,
  input  logic [ADDR_WIDTH-1:0] pipe_addr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic                  pipe_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_hold,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_owner,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DBG, ACK, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
  logic                 pipe_access;

  assign pipe_access = pipe_read | pipe_write;
  assign dbg_owner   = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    // Write wins at the memory if the pipeline ever raises both strobes.
    mem_read     = pipe_read & ~pipe_write;
    mem_write    = pipe_write;
    mem_address  = pipe_addr;
    mem_wdata    = pipe_wdata;
    pipe_stall   = 1'b0;
    dbg_ack      = 1'b0;
    dbg_rdata    = '0;

    case (state_q)
      IDLE: begin
        if (dbg_req) begin
          if (!pipe_access || starve_cnt_q == LIMIT) begin
            state_d      = DBG;
            starve_cnt_d = '0;
          end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      DBG: begin
        mem_read    = ~dbg_we;
        mem_write   = dbg_we;
        mem_address = dbg_addr;
        mem_wdata   = dbg_wdata;
        pipe_stall  = pipe_access;
        state_d     = ACK;
      end
      ACK: begin
        dbg_ack   = 1'b1;
        dbg_rdata = mem_rdata;
        state_d   = dbg_hold ? HOLD : IDLE;
      end
      HOLD: begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pipe_stall = pipe_access;
        if (dbg_req) begin
          state_d = DBG;
        end else if (!dbg_hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous pipeline read and write is an illegal MEM-stage request.
  a_no_pipe_rw: assert property (@(posedge clock) disable iff (!reset_n)
                                 !(pipe_read && pipe_write));

endmodule
